tetris_play_sequencer: RTL
==========================

# tetris_play_sequencer

Top-level play-state controller for the Tetris core. Sequences every change to the falling piece: spawn via `ld_cur`/`ld_next`, gravity, player moves and rotation, lock and line clear. Each candidate move is sent to the collision checker through a request/acknowledge handshake. A legal move is applied to the movement datapath with a one-cycle `commit` pulse. Sits between the input and tick generators and the movement controller / board RAM.

## Interface
- `LOCK_DELAY`, default 2: failed gravity steps tolerated before lock; legal range 1–7.
- `clk` in 1: single system clock.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; begins the game from IDLE or OVER.
- `tick_fall` in 1: one-cycle gravity pulse.
- `tick_fast` in 1: one-cycle soft-drop pulse; acts as gravity while `btn_down` is high.
- `btn_up`, `btn_left`, `btn_right` in 1 each: debounced levels (rotate, left, right).
- `btn_down` in 1: debounced level; enables soft drop.
- `chk_req` out 1: collision-check request; held until acknowledged.
- `chk_op` out 3: check operation. 0 DOWN, 1 LEFT, 2 RIGHT, 3 ROT, 4 SPAWN.
- `chk_ack` in 1: checker done; sampled only while `chk_req`=1.
- `chk_ok` in 1: move legal; valid with `chk_ack`.
- `commit` out 1: one-cycle pulse; the datapath applies `chk_op`.
- `ld_cur`, `ld_next` out 1: one-cycle spawn pulses; both assert together.
- `lock` out 1: one-cycle pulse; writes the piece into the board.
- `clear_req` out 1: line-clear request; held until `clear_done`.
- `clear_done` in 1: line clear complete.
- `game_over` out 1: level; high in OVER.
- `state_dbg` out 3: current state encoding.

## Operation
- States: IDLE, SPAWN, SPAWN_CHK, PLAY, CHECK, LOCK, CLEAR, OVER.
- IDLE: `start` → SPAWN.
- SPAWN:
  - `ld_cur` and `ld_next` pulse for one cycle.
  - Pending flags and the grounded counter clear.
  - → SPAWN_CHK.
- SPAWN_CHK: `chk_req`=1 with op SPAWN.
  - ack with ok=1 → PLAY.
  - ack with ok=0 → OVER.
- Pending flags G, R, L, Rt (gravity, rotate, left, right):
  - Set only in PLAY or CHECK.
  - G is set by `tick_fall`, or by `tick_fast & btn_down`.
  - R, L and Rt are set by rising edges of `btn_up`, `btn_left` and `btn_right`.
  - If a set and a clear hit the same flag in one cycle, set wins.
- PLAY: the highest-priority pending flag is chosen (G > R > L > Rt). Its op is latched into `chk_op` → CHECK. No flag pending → stay.
- CHECK: `chk_req`=1 and `chk_op` is stable until ack. On ack, the serviced flag clears, then:
  - ok=1 → `commit`. If op was DOWN, the grounded counter resets. → PLAY.
  - ok=0, op DOWN → grounded counter increments. If it reaches `LOCK_DELAY` → LOCK, else → PLAY.
  - ok=0, lateral/rotate → PLAY; no commit, counter unchanged.
- LOCK: `lock` pulses for one cycle → CLEAR.
- CLEAR: `clear_req`=1 until `clear_done` → SPAWN.
- OVER: `game_over`=1. `start` → SPAWN, and `game_over` falls on that edge.
- Grounded counter: 3 bits. Saturates at `LOCK_DELAY`; never wraps.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE.
  - `chk_req`, `commit`, `ld_cur`, `ld_next`, `lock`, `clear_req`, `game_over` = 0.
  - `chk_op` = 0.
  - `state_dbg` = 0.
  - All pending flags and the counter = 0.
- `resetn` low at any point, including mid-handshake, forces reset values immediately. A stale `chk_ack` after reset is ignored because `chk_req`=0.
- Tick sampled at edge n → `chk_req` high from cycle n+1.
- `chk_ack` sampled at edge m → `commit` high in cycle m+1 only; `chk_req` low in cycle m+1.
- Fastest move cycle with a same-cycle ack: 2 clocks per serviced request.
- `chk_ack` may assert in the first cycle `chk_req` is high, or any later cycle.
- `clear_done` sampled at edge k → `ld_cur`/`ld_next` high in cycle k+1.
- `start` is ignored outside IDLE and OVER.
- Ticks and button edges arriving in SPAWN, SPAWN_CHK, LOCK or CLEAR are dropped.

## Configuration
- `TETRIS_LOCK_DELAY_EN` defined:
  - Grounded counter and `LOCK_DELAY` behave as above.
  - Lateral moves and rotation stay possible while grounded.
- `TETRIS_LOCK_DELAY_EN` undefined:
  - The counter is not built; `LOCK_DELAY` is ignored.
  - The first DOWN with ok=0 → LOCK directly.

## Structure
- Shared package `tetris_pkg` holds:
  - the `chk_op` encoding constants (OP_DOWN, OP_LEFT, OP_RIGHT, OP_ROT, OP_SPAWN);
  - the state enum encoding used for `state_dbg`.
- One sub-module, `btn_edge_det`: registered rising-edge pulse generator, reset-clear.
  - Instantiated three times: up, left, right.

## Test plan
- Reset, `start`, spawn ack ok=1 → `ld_cur`=`ld_next`=1 for exactly one cycle, then `chk_op`=4. Ends in PLAY with `game_over`=0.
- Spawn ack ok=0 → OVER with `game_over`=1. A later `start` → SPAWN pulse and `game_over`=0.
- In PLAY, `tick_fall` and a `btn_left` edge in the same cycle → first check op 0, second op 1. Both acked ok=1 → two `commit` pulses in that order.
- `LOCK_DELAY`=2 with the macro on: two DOWN checks with ok=0 → `lock` pulse after the second; `clear_req` held until `clear_done` 5 cycles later; `ld_cur` the next cycle. Macro off: `lock` after the first.
- `chk_ack` delayed 10 cycles → `chk_req` and `chk_op` stable throughout. Asserting `resetn`=0 mid-wait → all outputs 0 and state IDLE immediately.
- `btn_right` held high for 20 cycles → exactly one RIGHT check. A button edge arriving during CLEAR → no check after respawn.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared encodings for the Tetris play sequencer: checker op codes, FSM state
// encoding (exported on state_dbg) and pending-flag helpers.
package tetris_pkg;

    localparam logic [2:0] OP_DOWN  = 3'd0;
    localparam logic [2:0] OP_LEFT  = 3'd1;
    localparam logic [2:0] OP_RIGHT = 3'd2;
    localparam logic [2:0] OP_ROT   = 3'd3;
    localparam logic [2:0] OP_SPAWN = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SPAWN     = 3'd1,
        ST_SPAWN_CHK = 3'd2,
        ST_PLAY      = 3'd3,
        ST_CHECK     = 3'd4,
        ST_LOCK      = 3'd5,
        ST_CLEAR     = 3'd6,
        ST_OVER      = 3'd7
    } state_e;

    // Pending-flag bit positions: gravity, rotate, left, right
    localparam int unsigned PF_G  = 0;
    localparam int unsigned PF_R  = 1;
    localparam int unsigned PF_L  = 2;
    localparam int unsigned PF_RT = 3;

    function automatic logic [2:0] pick_op(input logic [3:0] pend);
        if (pend[PF_G]) return OP_DOWN;
        if (pend[PF_R]) return OP_ROT;
        if (pend[PF_L]) return OP_LEFT;
        return OP_RIGHT;
    endfunction

    function automatic logic [3:0] op_flag(input logic [2:0] op);
        logic [3:0] f;
        f = '0;
        case (op)
            OP_DOWN:  f[PF_G]  = 1'b1;
            OP_ROT:   f[PF_R]  = 1'b1;
            OP_LEFT:  f[PF_L]  = 1'b1;
            OP_RIGHT: f[PF_RT] = 1'b1;
            default:  f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/btn_edge_det.sv
// Registered rising-edge detector for a debounced button level; the pulse
// lags the level change by one clock.
module btn_edge_det (
    input  logic clk,
    input  logic resetn,
    input  logic lvl_i,
    output logic rise_o
);

    logic lvl_q;
    logic rise_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lvl_q  <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            lvl_q  <= lvl_i;
            rise_q <= lvl_i & ~lvl_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/tetris_play_sequencer.sv
// Play-state controller for the Tetris core: spawn, gravity, moves, lock, clear.
// Optional grounded-counter lock delay is enabled by `define TETRIS_LOCK_DELAY_EN.
module tetris_play_sequencer
    import tetris_pkg::*;
#(
    parameter int unsigned LOCK_DELAY = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       tick_fall,
    input  logic       tick_fast,
    input  logic       btn_up,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_down,
    output logic       chk_req,
    output logic [2:0] chk_op,
    input  logic       chk_ack,
    input  logic       chk_ok,
    output logic       commit,
    output logic       ld_cur,
    output logic       ld_next,
    output logic       lock,
    output logic       clear_req,
    input  logic       clear_done,
    output logic       game_over,
    output logic [2:0] state_dbg
);

    state_e     state_q;
    logic [3:0] pend_q, pend_d, pend_set;
    logic [2:0] chk_op_q;
    logic       chk_req_q, commit_q, ld_q, lock_q, clear_req_q, game_over_q;
    logic       up_rise, left_rise, right_rise;

`ifdef TETRIS_LOCK_DELAY_EN
    localparam logic [2:0] LD3 = 3'(LOCK_DELAY);
    logic [2:0] cnt_q;
`else
    // LOCK_DELAY stays on the interface for drop-in compatibility only
    logic unused_lock_delay;
    assign unused_lock_delay = ^LOCK_DELAY;
`endif

    btn_edge_det u_up    (.clk(clk), .resetn(resetn), .lvl_i(btn_up),    .rise_o(up_rise));
    btn_edge_det u_left  (.clk(clk), .resetn(resetn), .lvl_i(btn_left),  .rise_o(left_rise));
    btn_edge_det u_right (.clk(clk), .resetn(resetn), .lvl_i(btn_right), .rise_o(right_rise));

    // Same-cycle sets feed PLAY directly so a tick is serviced on the next edge
    always_comb begin
        pend_set = '0;
        if (state_q == ST_PLAY || state_q == ST_CHECK)
            pend_set = {right_rise, left_rise, up_rise, tick_fall | (tick_fast & btn_down)};
        pend_d = pend_q | pend_set;
        if (state_q == ST_SPAWN)
            pend_d = '0;
        else if (state_q == ST_CHECK && chk_ack)
            pend_d = (pend_q & ~op_flag(chk_op_q)) | pend_set;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            pend_q      <= '0;
            chk_op_q    <= '0;
            chk_req_q   <= 1'b0;
            commit_q    <= 1'b0;
            ld_q        <= 1'b0;
            lock_q      <= 1'b0;
            clear_req_q <= 1'b0;
            game_over_q <= 1'b0;
`ifdef TETRIS_LOCK_DELAY_EN
            cnt_q       <= '0;
`endif
        end else begin
            commit_q <= 1'b0;
            ld_q     <= 1'b0;
            lock_q   <= 1'b0;
            pend_q   <= pend_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        ld_q    <= 1'b1;
                        state_q <= ST_SPAWN;
                    end
                end
                ST_SPAWN: begin
`ifdef TETRIS_LOCK_DELAY_EN
                    cnt_q     <= '0;
`endif
                    chk_req_q <= 1'b1;
                    chk_op_q  <= OP_SPAWN;
                    state_q   <= ST_SPAWN_CHK;
                end
                ST_SPAWN_CHK: begin
                    if (chk_ack) begin
                        chk_req_q <= 1'b0;
                        if (chk_ok) begin
                            state_q <= ST_PLAY;
                        end else begin
                            game_over_q <= 1'b1;
                            state_q     <= ST_OVER;
                        end
                    end
                end
                ST_PLAY: begin
                    if (|pend_d) begin
                        chk_op_q  <= pick_op(pend_d);
                        chk_req_q <= 1'b1;
                        state_q   <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (chk_ack) begin
                        chk_req_q <= 1'b0;
                        if (chk_ok) begin
                            commit_q <= 1'b1;
`ifdef TETRIS_LOCK_DELAY_EN
                            if (chk_op_q == OP_DOWN)
                                cnt_q <= '0;
`endif
                            state_q <= ST_PLAY;
                        end else if (chk_op_q == OP_DOWN) begin
`ifdef TETRIS_LOCK_DELAY_EN
                            if (cnt_q >= LD3 - 3'd1) begin
                                cnt_q   <= LD3;
                                lock_q  <= 1'b1;
                                state_q <= ST_LOCK;
                            end else begin
                                cnt_q   <= cnt_q + 3'd1;
                                state_q <= ST_PLAY;
                            end
`else
                            lock_q  <= 1'b1;
                            state_q <= ST_LOCK;
`endif
                        end else begin
                            state_q <= ST_PLAY;
                        end
                    end
                end
                ST_LOCK: begin
                    clear_req_q <= 1'b1;
                    state_q     <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    if (clear_done) begin
                        clear_req_q <= 1'b0;
                        ld_q        <= 1'b1;
                        state_q     <= ST_SPAWN;
                    end
                end
                ST_OVER: begin
                    if (start) begin
                        game_over_q <= 1'b0;
                        ld_q        <= 1'b1;
                        state_q     <= ST_SPAWN;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign chk_req   = chk_req_q;
    assign chk_op    = chk_op_q;
    assign commit    = commit_q;
    assign ld_cur    = ld_q;
    assign ld_next   = ld_q;
    assign lock      = lock_q;
    assign clear_req = clear_req_q;
    assign game_over = game_over_q;
    assign state_dbg = state_q;

endmodule
